obi_buffer: RTL
===============

# obi_buffer

Parametrised OBI buffer stage that replaces a single-entry register cut with independent request and response FIFOs of configurable depth. It adds credit-based flow control, so the downstream response path never stalls, plus occupancy/status outputs for debug. It sits between an OBI manager (upstream, subordinate port) and an OBI subordinate (downstream, manager port) on long or bursty interconnect paths. Any depth of 0 degenerates that channel to a combinational pass-through.

## Interface
- ObiCfg, obi_pkg::ObiDefaultConfig: OBI configuration shared by both ports; both ports must use the same configuration.
- obi_req_t, logic: full OBI request struct (A channel + req + rready).
- obi_rsp_t, logic: full OBI response struct (R channel + gnt + rvalid).
- ReqDepth, 2: request FIFO entries, 0..16; 0 means bypass.
- RspDepth, 2: response FIFO entries and maximum in-flight downstream transactions, 1..16.
- CntW, derived $clog2(max(ReqDepth,RspDepth)+1): width of the status counters.

Ports:
- clk_i  in  1  clock.
- rst_i  in  1  reset; synchronous, active-high.
- sbr_port_req_i  in  obi_req_t  request from the upstream manager.
- sbr_port_rsp_o  out  obi_rsp_t  response to the upstream manager.
- mgr_port_req_o  out  obi_req_t  request to the downstream subordinate.
- mgr_port_rsp_i  in  obi_rsp_t  response from the downstream subordinate.
- req_fill_o  out  CntW  request FIFO occupancy.
- rsp_fill_o  out  CntW  response FIFO occupancy.
- inflight_o  out  CntW  transactions issued downstream whose response has not yet been handed upstream.
- idle_o  out  1  high when both FIFOs are empty and inflight_o is 0.

## Operation
- Upstream A handshake (req & gnt) pushes the A channel into the request FIFO.
- sbr gnt = request FIFO not full. gnt has no combinational dependency on mgr gnt or sbr rready.
- mgr req = request FIFO not empty AND inflight_o < RspDepth. The A payload is the FIFO head.
- Downstream A handshake pops the request FIFO and increments inflight.
- Once mgr req is high, it and its payload stay stable until gnt. The credit condition cannot drop, because inflight only decrements while mgr req is waiting.
- Downstream R handshake pushes the R channel into the response FIFO.
- mgr rready is tied to 1. Credit gating guarantees that the FIFO has space.
- sbr rvalid = response FIFO not empty. The R payload is the FIFO head.
- Upstream R handshake (rvalid & rready) pops the response FIFO and decrements inflight.
- When an increment and a decrement of inflight occur in the same cycle, the net change is 0.
- If ObiCfg has no RReady, the upstream rready is taken as 1.
- Pointers wrap modulo depth; depths need not be powers of two.
- Responses stay in order; the block never reorders or drops a transaction.
- Reset empties both FIFOs and clears inflight. Transactions in flight at reset are discarded; the system must quiesce before asserting rst_i.

## Timing
- Reset values:
  - sbr gnt = 1 (ReqDepth>0); sbr rvalid = 0.
  - mgr req = 0; mgr rready = 1.
  - fills = 0, inflight_o = 0, idle_o = 1.
- Request latency: 1 cycle from the upstream handshake to mgr req. There is no fall-through.
- Response latency: 1 cycle from mgr rvalid to sbr rvalid.
- Full-throughput streaming needs ReqDepth ≥ 2 and RspDepth ≥ round-trip latency + 1.
- Request FIFO full with a pop in the same cycle: sbr gnt stays 0 that cycle.
- Response FIFO empty with a push in the same cycle: sbr rvalid rises the next cycle.
- ReqDepth = 0: the A channel is combinational. sbr gnt = mgr gnt & credit, and mgr req = sbr req & credit.

## Structure
- Package obi_buffer_pkg: function cnt_width(depth), and an elaboration check that enforces the parameter ranges.
- One sub-module, obi_buffer_fifo: a generic, parametrised-type, synchronous active-high-reset FIFO with push/pop/full/empty/fill. It is instantiated once per channel.
- Credit counter and status logic live in the top level.

## Test plan
- Reset, then idle:
  - All outputs at their reset values; idle_o = 1.
  - After 10 idle cycles, no output has changed.
- Single read (ReqDepth=2, RspDepth=2), addr 0x100 granted at cycle 0, downstream responds rdata 0xCAFE at cycle 3:
  - mgr req at cycle 1.
  - sbr rvalid with 0xCAFE at cycle 4.
  - inflight_o = 1 during cycles 2–4, back to 0 after.
- Credit stall (RspDepth=2), upstream rready held 0, 4 requests issued:
  - Exactly 2 downstream handshakes.
  - mgr req stays 0 with the FIFO non-empty.
  - After rready rises, the remaining 2 issue in order.
- Backpressure on the request side (ReqDepth=3), downstream gnt held 0, 5 requests offered:
  - sbr gnt falls after 3 accepts; req_fill_o = 3.
  - No accept occurs in the cycle of the first downstream pop.
- Streaming, 100 random transactions with random gnt, rvalid and rready:
  - Scoreboard confirms in-order, lossless data and inflight_o ≤ RspDepth at all times.
- Reset mid-operation with 2 requests queued and 1 response buffered:
  - Next cycle: fills = 0, inflight_o = 0, sbr rvalid = 0, mgr req = 0.

Source files
------------

// File: rtl/obi_buffer_pkg.sv
// Shared types, configuration and parameter helpers for the OBI buffer stage.
// Each buffered channel is a plain packed struct, so one generic FIFO can carry either channel.
package obi_buffer_pkg;

    localparam int unsigned AddrWidth = 32;
    localparam int unsigned DataWidth = 32;
    localparam int unsigned IdWidth   = 2;

    typedef struct packed {
        logic use_rready;
    } obi_cfg_t;

    localparam obi_cfg_t ObiDefaultConfig = '{use_rready: 1'b1};

    typedef struct packed {
        logic [AddrWidth-1:0]   addr;
        logic                   we;
        logic [DataWidth/8-1:0] be;
        logic [DataWidth-1:0]   wdata;
        logic [IdWidth-1:0]     aid;
    } obi_a_chan_t;

    typedef struct packed {
        obi_a_chan_t a;
        logic        req;
        logic        rready;
    } obi_req_t;

    typedef struct packed {
        logic [DataWidth-1:0] rdata;
        logic [IdWidth-1:0]   rid;
        logic                 err;
    } obi_r_chan_t;

    typedef struct packed {
        obi_r_chan_t r;
        logic        gnt;
        logic        rvalid;
    } obi_rsp_t;

    function automatic int unsigned cnt_width(input int unsigned depth);
        return (depth < 1) ? 1 : $clog2(depth + 1);
    endfunction

    function automatic bit depths_valid(input int unsigned req_depth, input int unsigned rsp_depth);
        return (req_depth <= 16) && (rsp_depth >= 1) && (rsp_depth <= 16);
    endfunction

endpackage

// File: rtl/obi_buffer_fifo.sv
// Generic synchronous FIFO with push/pop, full/empty and occupancy.
// Pointers wrap modulo Depth, so Depth need not be a power of two.
module obi_buffer_fifo
    import obi_buffer_pkg::*;
#(
    parameter int unsigned Depth = 2,
    parameter int unsigned CntW  = 2,
    parameter type         data_t = logic
) (
    input  logic            clk_i,
    input  logic            rst_i,
    input  logic            push_i,
    input  data_t           data_i,
    input  logic            pop_i,
    output data_t           data_o,
    output logic            full_o,
    output logic            empty_o,
    output logic [CntW-1:0] fill_o
);

    localparam int unsigned PtrW = (Depth > 1) ? $clog2(Depth) : 1;

    data_t           mem [Depth];
    logic [PtrW-1:0] wr_ptr;
    logic [PtrW-1:0] rd_ptr;
    logic [CntW-1:0] count;
    logic            do_push;
    logic            do_pop;

    function automatic logic [PtrW-1:0] wrap_inc(input logic [PtrW-1:0] ptr);
        return (ptr == PtrW'(Depth - 1)) ? '0 : ptr + PtrW'(1);
    endfunction

    assign full_o  = (count == CntW'(Depth));
    assign empty_o = (count == '0);
    assign fill_o  = count;
    assign data_o  = mem[rd_ptr];
    assign do_push = push_i & ~full_o;
    assign do_pop  = pop_i & ~empty_o;

    always_ff @(posedge clk_i) begin
        if (do_push) begin
            mem[wr_ptr] <= data_i;
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) begin
                wr_ptr <= wrap_inc(wr_ptr);
            end
            if (do_pop) begin
                rd_ptr <= wrap_inc(rd_ptr);
            end
            case ({do_push, do_pop})
                2'b10:   count <= count + CntW'(1);
                2'b01:   count <= count - CntW'(1);
                default: count <= count;
            endcase
        end
    end

endmodule

// File: rtl/obi_buffer.sv
// OBI buffer stage: request and response FIFOs with credit-based issue so the
// downstream response path can always be accepted (mgr rready tied high).
module obi_buffer
    import obi_buffer_pkg::*;
#(
    parameter obi_cfg_t    ObiCfg    = ObiDefaultConfig,
    parameter type         a_chan_t  = obi_buffer_pkg::obi_a_chan_t,
    parameter type         r_chan_t  = obi_buffer_pkg::obi_r_chan_t,
    parameter type         obi_req_t = obi_buffer_pkg::obi_req_t,
    parameter type         obi_rsp_t = obi_buffer_pkg::obi_rsp_t,
    parameter int unsigned ReqDepth  = 2,
    parameter int unsigned RspDepth  = 2,
    parameter int unsigned CntW      = cnt_width((ReqDepth > RspDepth) ? ReqDepth : RspDepth)
) (
    input  logic            clk_i,
    input  logic            rst_i,
    input  obi_req_t        sbr_port_req_i,
    output obi_rsp_t        sbr_port_rsp_o,
    output obi_req_t        mgr_port_req_o,
    input  obi_rsp_t        mgr_port_rsp_i,
    output logic [CntW-1:0] req_fill_o,
    output logic [CntW-1:0] rsp_fill_o,
    output logic [CntW-1:0] inflight_o,
    output logic            idle_o
);

    if (!depths_valid(ReqDepth, RspDepth)) begin : g_bad_params
        $error("obi_buffer: ReqDepth must be 0..16 and RspDepth 1..16");
    end

    logic            credit;
    logic            mgr_req;
    logic            sbr_gnt;
    logic            a_issue;
    logic            rready_up;
    logic            r_pop;
    logic            req_empty;
    logic            rsp_empty;
    logic            rsp_full_unused;
    logic [CntW-1:0] req_fill;
    logic [CntW-1:0] rsp_fill;
    logic [CntW-1:0] inflight_q;
    a_chan_t         req_head;
    r_chan_t         rsp_head;

    // A slot is held from downstream grant until the response leaves upstream,
    // which guarantees space in the response FIFO for every issued request.
    assign credit = (inflight_q < CntW'(RspDepth));

    if (ReqDepth == 0) begin : g_req_bypass
        assign req_head  = sbr_port_req_i.a;
        assign mgr_req   = sbr_port_req_i.req & credit;
        assign sbr_gnt   = mgr_port_rsp_i.gnt & credit;
        assign req_fill  = '0;
        assign req_empty = 1'b1;
    end else begin : g_req_fifo
        logic req_full;
        logic req_push;
        logic req_pop;

        assign req_push = sbr_port_req_i.req & ~req_full;
        assign req_pop  = mgr_req & mgr_port_rsp_i.gnt;
        assign sbr_gnt  = ~req_full;
        assign mgr_req  = ~req_empty & credit;

        obi_buffer_fifo #(
            .Depth  (ReqDepth),
            .CntW   (CntW),
            .data_t (a_chan_t)
        ) i_req_fifo (
            .clk_i   (clk_i),
            .rst_i   (rst_i),
            .push_i  (req_push),
            .data_i  (sbr_port_req_i.a),
            .pop_i   (req_pop),
            .data_o  (req_head),
            .full_o  (req_full),
            .empty_o (req_empty),
            .fill_o  (req_fill)
        );
    end

    assign a_issue   = mgr_req & mgr_port_rsp_i.gnt;
    assign rready_up = ObiCfg.use_rready ? sbr_port_req_i.rready : 1'b1;
    assign r_pop     = ~rsp_empty & rready_up;

    obi_buffer_fifo #(
        .Depth  (RspDepth),
        .CntW   (CntW),
        .data_t (r_chan_t)
    ) i_rsp_fifo (
        .clk_i   (clk_i),
        .rst_i   (rst_i),
        .push_i  (mgr_port_rsp_i.rvalid),
        .data_i  (mgr_port_rsp_i.r),
        .pop_i   (r_pop),
        .data_o  (rsp_head),
        .full_o  (rsp_full_unused),
        .empty_o (rsp_empty),
        .fill_o  (rsp_fill)
    );

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            inflight_q <= '0;
        end else if (a_issue && !r_pop) begin
            inflight_q <= inflight_q + CntW'(1);
        end else if (!a_issue && r_pop) begin
            inflight_q <= inflight_q - CntW'(1);
        end
    end

    always_comb begin
        mgr_port_req_o        = '0;
        mgr_port_req_o.a      = req_head;
        mgr_port_req_o.req    = mgr_req;
        mgr_port_req_o.rready = 1'b1;

        sbr_port_rsp_o        = '0;
        sbr_port_rsp_o.r      = rsp_head;
        sbr_port_rsp_o.gnt    = sbr_gnt;
        sbr_port_rsp_o.rvalid = ~rsp_empty;
    end

    assign req_fill_o = req_fill;
    assign rsp_fill_o = rsp_fill;
    assign inflight_o = inflight_q;
    assign idle_o     = req_empty & rsp_empty & (inflight_q == '0);

endmodule
